// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline register of the pipelined RV32I core. It captures the
//   decoder's control bundles (EX/M/WB) together with operand data, the
//   immediate, the PC and the register indices, and presents them to EX one
//   cycle later. It also detects load-use hazards against the instruction
//   currently in EX.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   id_valid               ID slot holds a real instruction
//   id_pc, id_rs1_data,
//   id_rs2_data, id_imm    XLEN-wide datapath fields from ID
//   id_rs1, id_rs2, id_rd  register indices from ID
//   id_ex_ctrl             {alu_src_b, alu_op[3:0]}
//   id_m_ctrl              {branch, b_type, mem_write}
//   id_wb_ctrl             {reg_write, mem_to_reg[1:0]}
//   stall                  downstream hold request
//   flush                  branch/jump redirect kill
//   ex_*                   registered copies of the id_* fields
//   load_use_hazard        IF/ID must hold this cycle (combinational)
//   bubble_cnt, flush_cnt  event counters (present with ID_EX_PERF_CNT_EN)
//
// Configuration
//   ID_EX_PERF_CNT_EN      when defined, bubble_cnt/flush_cnt count bubbles and
//                          flushes; when undefined both ports are tied to 0
//                          and no counter flops exist.
//
// Slot semantics: ex_valid qualifies the EX slot. A slot with ex_valid=0
// always carries all-zero control bundles, so it has no architectural side
// effect. Per clock edge the priority is flush > stall > hazard bubble >
// load. A flush or bubble clears ex_valid and the control bundles while the
// data/index fields hold; stall holds every register.
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [4:0]      id_ex_ctrl,
  input  logic [2:0]      id_m_ctrl,
  input  logic [2:0]      id_wb_ctrl,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic [4:0]      ex_ex_ctrl,
  output logic [2:0]      ex_m_ctrl,
  output logic [2:0]      ex_wb_ctrl,
  output logic            load_use_hazard,
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     flush_cnt
);

  // A load in EX is reg_write=1 with mem_to_reg selecting memory data (2'b11).
  logic ex_is_load;
  logic rd_matches;
  logic do_bubble;
  logic do_flush;

  assign ex_is_load = ex_valid && ex_wb_ctrl[2] && (ex_wb_ctrl[1:0] == 2'b11);
  assign rd_matches = (ex_rd == id_rs1) || (ex_rd == id_rs2);

  // x0 is never really written, so a load to x0 cannot create a dependency.
  assign load_use_hazard = ex_is_load && (ex_rd != '0) && id_valid && rd_matches;

  // Stall outranks the bubble: while EX is held, the load stays put and the
  // dependent instruction simply waits in ID.
  assign do_flush  = flush;
  assign do_bubble = !flush && !stall && load_use_hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ex_ctrl  <= '0;
      ex_m_ctrl   <= '0;
      ex_wb_ctrl  <= '0;
    end else if (do_flush || do_bubble) begin
      // Kill the slot; data/index fields hold their previous values.
      ex_valid   <= 1'b0;
      ex_ex_ctrl <= '0;
      ex_m_ctrl  <= '0;
      ex_wb_ctrl <= '0;
    end else if (!stall) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      // An invalid slot must never carry live control into EX.
      ex_ex_ctrl  <= id_valid ? id_ex_ctrl : 5'b0;
      ex_m_ctrl   <= id_valid ? id_m_ctrl  : 3'b0;
      ex_wb_ctrl  <= id_valid ? id_wb_ctrl : 3'b0;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Free-running 32-bit counters; natural wrap from 0xFFFFFFFF to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (do_bubble) bubble_cnt <= bubble_cnt + 32'd1;
      if (do_flush)  flush_cnt  <= flush_cnt + 32'd1;
    end
  end
`else
  assign bubble_cnt = 32'd0;
  assign flush_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
//   Directed bench for id_ex_stage_reg: reset (including asynchronous reset
//   mid-cycle), normal load, load-use bubble via rs1 and rs2, hazard under
//   stall, x0 destination, stall hold, flush over stall, invalid-slot masking
//   and the optional performance counters.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic [4:0]      id_ex_ctrl;
  logic [2:0]      id_m_ctrl, id_wb_ctrl;
  logic            stall, flush;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [4:0]      ex_ex_ctrl;
  logic [2:0]      ex_m_ctrl, ex_wb_ctrl;
  logic            load_use_hazard;
  logic [31:0]     bubble_cnt, flush_cnt;

  int vectors_applied;
  int miscompares;

  id_ex_stage_reg #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_rs1_data     (id_rs1_data),
    .id_rs2_data     (id_rs2_data),
    .id_imm          (id_imm),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_ex_ctrl      (id_ex_ctrl),
    .id_m_ctrl       (id_m_ctrl),
    .id_wb_ctrl      (id_wb_ctrl),
    .stall           (stall),
    .flush           (flush),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_rs1_data     (ex_rs1_data),
    .ex_rs2_data     (ex_rs2_data),
    .ex_imm          (ex_imm),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_rd           (ex_rd),
    .ex_ex_ctrl      (ex_ex_ctrl),
    .ex_m_ctrl       (ex_m_ctrl),
    .ex_wb_ctrl      (ex_wb_ctrl),
    .load_use_hazard (load_use_hazard),
    .bubble_cnt      (bubble_cnt),
    .flush_cnt       (flush_cnt)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [4:0] exc, input logic [2:0] mc, input logic [2:0] wbc);
    id_valid = v;  id_pc = pc;  id_rs1_data = d1;  id_rs2_data = d2;  id_imm = imm;
    id_rs1 = rs1;  id_rs2 = rs2;  id_rd = rd;
    id_ex_ctrl = exc;  id_m_ctrl = mc;  id_wb_ctrl = wbc;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors_applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 3'd0);
    tick();
    tick();

    // Reset state
    check("rst_valid",   {31'b0, ex_valid}, 32'd0);
    check("rst_pc",      ex_pc, 32'd0);
    check("rst_wb",      {29'b0, ex_wb_ctrl}, 32'd0);
    check("rst_hazard",  {31'b0, load_use_hazard}, 32'd0);
    check("rst_bubbles", bubble_cnt, 32'd0);
    check("rst_flushes", flush_cnt, 32'd0);

    // Load a valid slot, then assert reset mid-cycle
    rst_n = 1'b1;
    drive_id(1'b1, 32'h40, 32'hAA, 32'hBB, 32'h3, 5'd1, 5'd2, 5'd3, 5'b00101, 3'b010, 3'b100);
    tick();
    check("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
    check("pre_rst_pc",    ex_pc, 32'h40);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, ex_valid}, 32'd0);
    check("async_rst_pc",    ex_pc, 32'd0);
    check("async_rst_exc",   {27'b0, ex_ex_ctrl}, 32'd0);
    check("async_rst_m",     {29'b0, ex_m_ctrl}, 32'd0);
    check("async_rst_rs1d",  ex_rs1_data, 32'd0);
    #1 rst_n = 1'b1;
    drive_id(1'b1, 32'h100, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 3'd0);
    tick();
    check("post_rst_pc",    ex_pc, 32'h100);
    check("post_rst_valid", {31'b0, ex_valid}, 32'd1);

    // Normal load: ADDI x5, x1, 7
    drive_id(1'b1, 32'h104, 32'h11, 32'h22, 32'd7, 5'd1, 5'd0, 5'd5, 5'b10000, 3'b000, 3'b100);
    tick();
    check("addi_exc",  {27'b0, ex_ex_ctrl}, 32'b10000);
    check("addi_wb",   {29'b0, ex_wb_ctrl}, 32'b100);
    check("addi_imm",  ex_imm, 32'd7);
    check("addi_rd",   {27'b0, ex_rd}, 32'd5);
    check("addi_rs1d", ex_rs1_data, 32'h11);
    check("addi_haz",  {31'b0, load_use_hazard}, 32'd0);

    // Load-use via rs1: lw x5 in EX, add x7, x5, x6 in ID
    drive_id(1'b1, 32'h108, 32'h1000, 32'h0, 32'd4, 5'd2, 5'd0, 5'd5, 5'b10000, 3'b000, 3'b111);
    tick();
    drive_id(1'b1, 32'h10C, 32'h5, 32'h6, 32'd0, 5'd5, 5'd6, 5'd7, 5'b00000, 3'b000, 3'b100);
    #1;
    check("lu_rs1_haz", {31'b0, load_use_hazard}, 32'd1);
    tick();
    check("bubble_valid",   {31'b0, ex_valid}, 32'd0);
    check("bubble_exc",     {27'b0, ex_ex_ctrl}, 32'd0);
    check("bubble_m",       {29'b0, ex_m_ctrl}, 32'd0);
    check("bubble_wb",      {29'b0, ex_wb_ctrl}, 32'd0);
    check("bubble_pc_hold", ex_pc, 32'h108);
    check("bubble_cnt_1",   bubble_cnt, PERF ? 32'd1 : 32'd0);
    check("bubble_haz_off", {31'b0, load_use_hazard}, 32'd0);
    tick();
    check("add_pc",    ex_pc, 32'h10C);
    check("add_valid", {31'b0, ex_valid}, 32'd1);
    check("add_rd",    {27'b0, ex_rd}, 32'd7);

    // Load-use via rs2, with stall holding the load in EX first
    drive_id(1'b1, 32'h110, 32'h0, 32'h0, 32'd8, 5'd2, 5'd0, 5'd9, 5'b10000, 3'b000, 3'b111);
    tick();
    drive_id(1'b1, 32'h114, 32'h3, 32'h9, 32'd0, 5'd3, 5'd9, 5'd10, 5'b00000, 3'b000, 3'b100);
    stall = 1'b1;
    #1;
    check("lu_rs2_haz", {31'b0, load_use_hazard}, 32'd1);
    tick();
    check("stall_haz_valid", {31'b0, ex_valid}, 32'd1);
    check("stall_haz_pc",    ex_pc, 32'h110);
    check("stall_haz_wb",    {29'b0, ex_wb_ctrl}, 32'b111);
    check("stall_haz_cnt",   bubble_cnt, PERF ? 32'd1 : 32'd0);
    stall = 1'b0;
    tick();
    check("bubble2_valid", {31'b0, ex_valid}, 32'd0);
    check("bubble2_cnt",   bubble_cnt, PERF ? 32'd2 : 32'd0);
    tick();
    check("dep_pc", ex_pc, 32'h114);

    // x0 destination never raises the hazard
    drive_id(1'b1, 32'h118, 32'h0, 32'h0, 32'd0, 5'd2, 5'd0, 5'd0, 5'b10000, 3'b000, 3'b111);
    tick();
    drive_id(1'b1, 32'h11C, 32'h0, 32'h0, 32'd0, 5'd0, 5'd0, 5'd12, 5'b00011, 3'b000, 3'b100);
    #1;
    check("x0_haz", {31'b0, load_use_hazard}, 32'd0);
    tick();
    check("x0_add_pc",    ex_pc, 32'h11C);
    check("x0_add_valid", {31'b0, ex_valid}, 32'd1);
    check("x0_add_exc",   {27'b0, ex_ex_ctrl}, 32'b00011);

    // Stall three cycles with different ID inputs: outputs hold
    drive_id(1'b1, 32'h120, 32'hDEAD, 32'hBEEF, 32'd99, 5'd20, 5'd21, 5'd22, 5'b11111, 3'b101, 3'b101);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc",    ex_pc, 32'h11C);
      check("stall_valid", {31'b0, ex_valid}, 32'd1);
      check("stall_rd",    {27'b0, ex_rd}, 32'd12);
      check("stall_exc",   {27'b0, ex_ex_ctrl}, 32'b00011);
    end

    // Flush together with stall: flush wins
    drive_id(1'b1, 32'h124, 32'h0, 32'h0, 32'd0, 5'd0, 5'd0, 5'd1, 5'b00001, 3'b100, 3'b100);
    tick();
    tick();
    check("pre_flush_m", {29'b0, ex_m_ctrl}, 32'd0);
    stall = 1'b0;
    tick();
    check("pre_flush_m2", {29'b0, ex_m_ctrl}, 32'b100);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    check("flush_valid",   {31'b0, ex_valid}, 32'd0);
    check("flush_m",       {29'b0, ex_m_ctrl}, 32'd0);
    check("flush_pc_hold", ex_pc, 32'h124);
    check("flush_cnt_1",   flush_cnt, PERF ? 32'd1 : 32'd0);
    stall = 1'b0;
    flush = 1'b0;

    // Invalid slot: hazard suppressed and control masked
    drive_id(1'b1, 32'h128, 32'h0, 32'h0, 32'd0, 5'd2, 5'd0, 5'd4, 5'b10000, 3'b000, 3'b111);
    tick();
    drive_id(1'b0, 32'h200, 32'h0, 32'h0, 32'd0, 5'd4, 5'd4, 5'd6, 5'b10101, 3'b001, 3'b100);
    #1;
    check("inv_haz", {31'b0, load_use_hazard}, 32'd0);
    tick();
    check("inv_m",     {29'b0, ex_m_ctrl}, 32'd0);
    check("inv_valid", {31'b0, ex_valid}, 32'd0);
    check("inv_wb",    {29'b0, ex_wb_ctrl}, 32'd0);
    check("inv_pc",    ex_pc, 32'h200);

    // Plain flush of a valid incoming instruction
    drive_id(1'b1, 32'h204, 32'h0, 32'h0, 32'd0, 5'd0, 5'd0, 5'd8, 5'b00001, 3'b001, 3'b100);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush2_valid", {31'b0, ex_valid}, 32'd0);
    check("flush2_wb",    {29'b0, ex_wb_ctrl}, 32'd0);
    check("flush_cnt_2",  flush_cnt, PERF ? 32'd2 : 32'd0);
    check("bubble_final", bubble_cnt, PERF ? 32'd2 : 32'd0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
